mem_io_bridge: RTL and testbench

- Data-side load/store unit between the riscv_cpu core and the single-port RAM IP ("ramm") plus memory-mapped IO.
- Takes byte/half/word requests over a req/ready handshake, decodes RAM vs IO, performs read-modify-write for sub-word stores (RAM has no byte enables) and extracts/sign-extends load data.
- Owns the LED register and an optional cycle counter.

---
 rtl/mem_io_bridge.sv | 163 ++++++++++++++++
 tb/tb_mem_io_bridge.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bridge.sv
// Data-side load/store bridge: RAM read-modify-write, load extract, LED/timer MMIO.
// Optional build macro MMIO_TIMER_EN adds a free-running counter at IO_BASE+4.
module mem_io_bridge #(
   parameter int          RAM_AW  = 12,
   parameter logic [31:0] IO_BASE = 32'hFFFF_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              uns,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              err,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_data,
   output logic              ram_wren,
   input  logic [31:0]       ram_q,
   output logic [3:0]        leds
);

   typedef enum logic [2:0] {
      IDLE, READ, WAIT, WRITE, IO, ERR
   } state_t;

   state_t            state, state_nxt;
   logic              c_we;
   logic              c_uns;
   logic [1:0]        c_size;
   logic [15:0]       c_off;
   logic [RAM_AW-1:0] c_waddr;
   logic [31:0]       wr_word;
   logic [31:0]       rdata_q;
   logic [31:0]       rdata_nxt;
   logic [31:0]       load_val;
   logic [31:0]       merged;
   logic [31:0]       io_val;
   logic [7:0]        ld_b;
   logic [15:0]       ld_h;
   logic              misal;
   logic              is_io;

`ifdef MMIO_TIMER_EN
   logic [31:0] counter;

   // free-running cycle counter, wraps naturally
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) counter <= '0;
      else        counter <= counter + 32'd1;
   end
`endif

   assign misal = (size == 2'd3)
               || (size == 2'd1 && addr[0])
               || (size == 2'd2 && addr[1:0] != 2'b00);
   assign is_io = (addr[31:16] == IO_BASE[31:16]);

   // lane extraction, sub-word merge and IO read mux
   always_comb begin
      ld_b   = ram_q[{c_off[1:0], 3'b000} +: 8];
      ld_h   = ram_q[{c_off[1], 4'b0000} +: 16];
      load_val = ram_q;
      merged   = ram_q;
      io_val   = '0;
      unique case (c_size)
         2'd0: begin
            load_val = {{24{ld_b[7] & ~c_uns}}, ld_b};
            merged[{c_off[1:0], 3'b000} +: 8] = wr_word[7:0];
         end
         2'd1: begin
            load_val = {{16{ld_h[15] & ~c_uns}}, ld_h};
            merged[{c_off[1], 4'b0000} +: 16] = wr_word[15:0];
         end
         default: ;
      endcase
      if (c_off == 16'h0000) io_val = {28'b0, leds};
`ifdef MMIO_TIMER_EN
      else if (c_off == 16'h0004) io_val = counter;
`endif
   end

   // next state and completion outputs
   always_comb begin
      state_nxt = state;
      rdata_nxt = rdata_q;
      ready     = 1'b0;
      err       = 1'b0;
      ram_wren  = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               if (misal)                   state_nxt = ERR;
               else if (is_io)              state_nxt = IO;
               else if (we && size == 2'd2) state_nxt = WRITE;
               else                         state_nxt = READ;
            end
         end
         READ: state_nxt = WAIT;
         WAIT: begin
            if (c_we) begin
               state_nxt = WRITE;
            end else begin
               ready     = 1'b1;
               rdata_nxt = load_val;
               state_nxt = IDLE;
            end
         end
         WRITE: begin
            ram_wren  = 1'b1;
            ready     = 1'b1;
            state_nxt = IDLE;
         end
         IO: begin
            ready = 1'b1;
            if (!c_we) rdata_nxt = io_val;
            state_nxt = IDLE;
         end
         ERR: begin
            ready     = 1'b1;
            err       = 1'b1;
            rdata_nxt = '0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rdata    = rdata_nxt;
   assign ram_addr = c_waddr;
   assign ram_data = wr_word;

   // state, request capture, merged write word, LED and rdata registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         c_we    <= 1'b0;
         c_uns   <= 1'b0;
         c_size  <= 2'd0;
         c_off   <= '0;
         c_waddr <= '0;
         wr_word <= '0;
         rdata_q <= '0;
         leds    <= '0;
      end else begin
         state   <= state_nxt;
         rdata_q <= rdata_nxt;
         if (state == IDLE && req) begin
            c_we    <= we;
            c_uns   <= uns;
            c_size  <= size;
            c_off   <= addr[15:0];
            c_waddr <= addr[RAM_AW+1:2];
            wr_word <= wdata;
         end
         if (state == WAIT && c_we) wr_word <= merged;
         if (state == IO && c_we && c_off == 16'h0000) leds <= wr_word[3:0];
      end
   end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed scoreboard bench for mem_io_bridge with a behavioural RAM model.
// Build with MMIO_TIMER_EN defined to exercise the timer register.
module tb_mem_io_bridge;

   localparam logic [31:0] IOB = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        req, we, uns;
   logic [1:0]  size;
   logic [31:0] addr, wdata, rdata, ram_data, ram_q;
   logic        ready, err, ram_wren;
   logic [11:0] ram_addr;
   logic [3:0]  leds;

   logic [31:0] mem [4096];
   int total = 0;
   int bad = 0;

   typedef struct {
      string       tag;
      logic        chk_rd;
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          wr_n;
      logic [31:0] wa;
      logic [31:0] wd;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   mem_io_bridge #(.RAM_AW(12), .IO_BASE(IOB)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
      .uns(uns), .addr(addr), .wdata(wdata), .rdata(rdata),
      .ready(ready), .err(err), .ram_addr(ram_addr),
      .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
      .leds(leds)
   );

   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic txn(input logic w, input logic [1:0] sz,
                      input logic u, input logic [31:0] a,
                      input logic [31:0] d, input exp_t e,
                      output logic [31:0] got);
      exp_t x;
      int k;
      int wn;
      logic [31:0] wa, wd;
      logic seen;
      sb.push_back(e);
      @(negedge clk);
      req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
      wn = 0; wa = '0; wd = '0; seen = 1'b0; got = '0;
      for (k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (ram_wren) begin
            wn++; wa = 32'(ram_addr); wd = ram_data;
         end
         if (ready) begin
            seen = 1'b1;
            break;
         end
      end
      x = sb.pop_front();
      got = rdata;
      chk({x.tag, "_ready"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({x.tag, "_lat"}, 32'(k), 32'(x.lat));
         chk({x.tag, "_err"}, 32'(err), 32'(x.er));
         if (x.chk_rd) chk({x.tag, "_rdata"}, rdata, x.rd);
         chk({x.tag, "_wren"}, 32'(wn), 32'(x.wr_n));
         if (x.wr_n > 0) begin
            chk({x.tag, "_waddr"}, wa, x.wa);
            chk({x.tag, "_wdata"}, wd, x.wd);
         end
      end
      req = 1'b0;
   endtask

   function automatic exp_t mk(input string t, input logic c,
                               input logic [31:0] r, input logic e,
                               input int l, input int n,
                               input logic [31:0] a,
                               input logic [31:0] d);
      exp_t x;
      x.tag = t; x.chk_rd = c; x.rd = r; x.er = e;
      x.lat = l; x.wr_n = n; x.wa = a; x.wd = d;
      return x;
   endfunction

   initial begin
      logic [31:0] g, t1, t2;
      logic wseen;
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0;
      uns = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_wren", 32'(ram_wren), 32'd0);
      chk("rst_ram_data", ram_data, 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_leds", 32'(leds), 32'd0);
      reset = 1'b1;

      txn(1, 2, 0, 32'h10, 32'hDEADBEEF,
          mk("sw10", 0, 0, 0, 1, 1, 4, 32'hDEADBEEF), g);
      txn(0, 2, 0, 32'h10, 0,
          mk("lw10", 1, 32'hDEADBEEF, 0, 2, 0, 0, 0), g);
      txn(1, 2, 0, 32'h8, 32'h11223344,
          mk("sw8", 0, 0, 0, 1, 1, 2, 32'h11223344), g);
      txn(1, 0, 0, 32'hA, 32'h000000AB,
          mk("sbA", 0, 0, 0, 3, 1, 2, 32'h11AB3344), g);
      txn(0, 0, 0, 32'hA, 0,
          mk("lbA", 1, 32'hFFFFFFAB, 0, 2, 0, 0, 0), g);
      txn(0, 0, 1, 32'hA, 0,
          mk("lbuA", 1, 32'h000000AB, 0, 2, 0, 0, 0), g);
      txn(0, 1, 0, 32'h8, 0,
          mk("lh8", 1, 32'h00003344, 0, 2, 0, 0, 0), g);
      txn(0, 1, 0, 32'hA, 0,
          mk("lhA", 1, 32'h000011AB, 0, 2, 0, 0, 0), g);
      txn(1, 1, 0, 32'h12, 32'h12348765,
          mk("sh12", 0, 0, 0, 3, 1, 4, 32'h8765BEEF), g);
      txn(0, 1, 0, 32'h12, 0,
          mk("lh12", 1, 32'hFFFF8765, 0, 2, 0, 0, 0), g);
      txn(0, 1, 1, 32'h12, 0,
          mk("lhu12", 1, 32'h00008765, 0, 2, 0, 0, 0), g);

      txn(0, 1, 0, 32'h3, 0,
          mk("lh3_mis", 1, 0, 1, 1, 0, 0, 0), g);
      txn(0, 2, 0, 32'h6, 0,
          mk("lw6_mis", 1, 0, 1, 1, 0, 0, 0), g);
      txn(0, 3, 0, 32'h0, 0,
          mk("sz3", 1, 0, 1, 1, 0, 0, 0), g);
      txn(1, 2, 0, 32'h5, 32'hCAFEF00D,
          mk("sw5_mis", 1, 0, 1, 1, 0, 0, 0), g);
      txn(0, 2, 0, 32'h4, 0,
          mk("lw4", 1, 32'h0, 0, 2, 0, 0, 0), g);

      txn(1, 2, 0, IOB, 32'h5,
          mk("io_led_w", 0, 0, 0, 1, 0, 0, 0), g);
      @(negedge clk);
      chk("leds_5", 32'(leds), 32'h5);
      txn(0, 2, 0, IOB, 0,
          mk("io_led_r", 1, 32'h5, 0, 1, 0, 0, 0), g);
      txn(1, 2, 0, IOB + 32'h8, 32'hA,
          mk("io_8_w", 0, 0, 0, 1, 0, 0, 0), g);
      @(negedge clk);
      chk("leds_keep", 32'(leds), 32'h5);
      txn(0, 2, 0, IOB + 32'h8, 0,
          mk("io_8_r", 1, 0, 0, 1, 0, 0, 0), g);

`ifdef MMIO_TIMER_EN
      txn(0, 2, 0, IOB + 32'h4, 0,
          mk("tmr_r1", 0, 0, 0, 1, 0, 0, 0), t1);
      repeat (8) @(negedge clk);
      txn(0, 2, 0, IOB + 32'h4, 0,
          mk("tmr_r2", 0, 0, 0, 1, 0, 0, 0), t2);
      chk("tmr_diff", t2 - t1, 32'd10);
`else
      t1 = '0; t2 = '0;
      txn(0, 2, 0, IOB + 32'h4, 0,
          mk("tmr_off", 1, 32'h0, 0, 1, 0, 0, 0), g);
`endif

      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'd1; uns = 1'b0;
      addr = 32'h8; wdata = 32'h00005555;
      @(negedge clk);
      req = 1'b0;
      wseen = ram_wren;
      @(negedge clk);
      wseen |= ram_wren;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         wseen |= ram_wren;
      end
      chk("rst_mid_wren", 32'(wseen), 32'd0);
      chk("rst_mid_leds", 32'(leds), 32'd0);
      chk("rst_mid_ready", 32'(ready), 32'd0);
      chk("rst_mid_rdata", rdata, 32'd0);
      reset = 1'b1;
      txn(0, 2, 0, 32'h8, 0,
          mk("lw8_post", 1, 32'h11AB3344, 0, 2, 0, 0, 0), g);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
